dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 is the

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_rr.sv | 21 ++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef logic master_id_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - 2-way round-robin picker; a tie goes to the port not granted last
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of single-port dmem between core and loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [CW-1:0] conflict_cnt
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state_q, state_d;
  master_id_t    last_grant_q, last_grant_d;
  master_id_t    id_q, id_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0] conflict_q, conflict_d;

  logic          gnt_valid;
  master_id_t    gnt_id;
  logic          misaligned;
  logic          issue;
  logic          rvalid;
  logic          waiting;

  dmem_arb_rr u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    misaligned = |(addr_q[1:0] & ALIGN_MASK);
    issue      = (state_q == ISSUE);
    rvalid     = (state_q == WAIT) && (cnt_q == '0);

    mem_en    = issue && !misaligned;
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;

    m0_ready  = issue && (id_q == 1'b0);
    m1_ready  = issue && (id_q == 1'b1);
    m0_err    = m0_ready && misaligned;
    m1_err    = m1_ready && misaligned;
    m0_rvalid = rvalid && (id_q == 1'b0);
    m1_rvalid = rvalid && (id_q == 1'b1);
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;

    busy         = (state_q != IDLE);
    grant_id     = busy ? id_q : 1'b0;
    conflict_cnt = conflict_q;

    // One count per cycle in which at least one port is left waiting
    waiting = (m0_req && !m0_ready) || (m1_req && !m1_ready);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    conflict_d   = conflict_q;

    if (waiting && (conflict_q != {CW{1'b1}})) begin
      conflict_d = conflict_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = ISSUE;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          we_d         = gnt_id ? m1_we    : m0_we;
          addr_d       = gnt_id ? m1_addr  : m0_addr;
          wdata_d      = gnt_id ? m1_wdata : m0_wdata;
        end
      end
      ISSUE: begin
        if (misaligned || we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      conflict_q   <= conflict_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter (RD_LAT=2, CW=4)
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, grant_id;
  logic [3:0]  conflict_cnt;

  int n_err;
  int n_chk;
  int ord[$];

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .CW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_ready     (m0_ready),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .m0_err       (m0_err),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_ready     (m1_ready),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .m1_err       (m1_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = 32'h19;
    repeat (2) next_cycle();
    reset = 1'b1;
    next_cycle();

    // Both ports hold store requests: grants alternate, counter climbs and saturates
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hB0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (m0_ready) ord.push_back(0);
      if (m1_ready) ord.push_back(1);
      if (c == 0) check("tie_idle_busy", busy, 0);
      if (c == 3) check("tie_m1_addr", mem_addr, 32'h20);
      if (c == 3) check("tie_m1_grant_id", grant_id, 1);
      if (c == 7) check("cnt_c7", conflict_cnt, 7);
      if (c == 15) check("cnt_sat", conflict_cnt, 15);
      if (c == 20) check("cnt_sat_hold", conflict_cnt, 15);
      next_cycle();
    end
    check("rr_count", ord.size(), 10);
    for (int i = 0; i < 4 && i < ord.size(); i++) check($sformatf("rr_order_%0d", i), ord[i], i % 2);

    // Reset asserted in ISSUE with traffic still present
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_ready", {m1_ready, m0_ready}, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_mem_addr", mem_addr, 0);
    next_cycle();
    m0_req = 0; m1_req = 0;
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // m0 store alone
    m0_req = 1; m0_we = 1; m0_addr = 32'h64; m0_wdata = 32'h19;
    @(negedge clk);
    check("st_c0_ready", m0_ready, 0);
    next_cycle();
    @(negedge clk);
    check("st_mem_en", mem_en, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_addr", mem_addr, 32'h64);
    check("st_mem_wdata", mem_wdata, 32'h19);
    check("st_ready", m0_ready, 1);
    check("st_busy", busy, 1);
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    check("st_idle", busy, 0);
    check("st_mem_en_off", mem_en, 0);
    check("st_cnt", conflict_cnt, 1);
    next_cycle();

    // m0 load, two-cycle memory latency
    m0_req = 1; m0_we = 0; m0_addr = 32'h64; m0_wdata = 32'h0;
    next_cycle();
    @(negedge clk);
    check("ld_ready", m0_ready, 1);
    check("ld_mem_we", mem_we, 0);
    check("ld_mem_en", mem_en, 1);
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    check("ld_wait_rvalid", m0_rvalid, 0);
    check("ld_wait_rdata", m0_rdata, 0);
    next_cycle();
    @(negedge clk);
    check("ld_rvalid", m0_rvalid, 1);
    check("ld_rdata", m0_rdata, 32'h19);
    check("ld_m1_rvalid", m1_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("ld_done", busy, 0);
    next_cycle();

    // m1 misaligned store
    m1_req = 1; m1_we = 1; m1_addr = 32'h66; m1_wdata = 32'h55;
    next_cycle();
    @(negedge clk);
    check("mis_ready", m1_ready, 1);
    check("mis_err", m1_err, 1);
    check("mis_mem_en", mem_en, 0);
    check("mis_m0_ready", m0_ready, 0);
    next_cycle();
    m1_req = 0;
    @(negedge clk);
    check("mis_idle", busy, 0);
    check("mis_err_off", m1_err, 0);
    next_cycle();

    // Reset while m0 load waits on memory
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    next_cycle();
    @(negedge clk);
    check("abt_ready", m0_ready, 1);
    next_cycle();
    m0_req = 0;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abt_rvalid_rst", m0_rvalid, 0);
      next_cycle();
    end
    reset = 1'b1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h77;
    @(negedge clk);
    check("abt_rvalid_after", m0_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("abt_m1_ready", m1_ready, 1);
    check("abt_m1_addr", mem_addr, 32'h80);
    next_cycle();
    m1_req = 0;
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
